// File: rtl/div_arbiter_if.sv
// rtl/div_arbiter_if.sv - requester and divider signal bundle for div_arbiter
interface div_arbiter_if #(
  parameter int WIDTH     = 16,
  parameter int RES_WIDTH = 12
);
  logic                 req1;
  logic [WIDTH-1:0]     dividend1;
  logic [WIDTH-1:0]     divisor1;
  logic                 req2;
  logic [WIDTH-1:0]     dividend2;
  logic [WIDTH-1:0]     divisor2;
  logic                 gnt1;
  logic                 gnt2;
  logic [RES_WIDTH-1:0] res;
  logic                 res_valid1;
  logic                 res_valid2;
  logic                 res_err;
  logic                 div_en;
  logic                 div_select;
  logic [WIDTH-1:0]     div_dividend;
  logic [WIDTH-1:0]     div_divisor;
  logic                 div_busy;
  logic                 div_ready;
  logic [RES_WIDTH-1:0] div_res;

  // arbiter side
  modport master (
    input  req1, dividend1, divisor1, req2, dividend2, divisor2,
    input  div_busy, div_ready, div_res,
    output gnt1, gnt2, res, res_valid1, res_valid2, res_err,
    output div_en, div_select, div_dividend, div_divisor
  );

  // requesters plus divider side
  modport slave (
    output req1, dividend1, divisor1, req2, dividend2, divisor2,
    output div_busy, div_ready, div_res,
    input  gnt1, gnt2, res, res_valid1, res_valid2, res_err,
    input  div_en, div_select, div_dividend, div_divisor
  );
endinterface

// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin sharing of one divider between speed and average-speed requesters
module div_arbiter #(
  parameter int WIDTH     = 16,
  parameter int RES_WIDTH = 12,
  parameter int TIMEOUT   = 64,
  parameter int TO_WIDTH  = 7
) (
  input logic           clock,
  input logic           reset,
  div_arbiter_if.master bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [TO_WIDTH-1:0]  TO_LAST = TO_WIDTH'(TIMEOUT - 1);
  localparam logic [TO_WIDTH-1:0]  TO_ONE  = TO_WIDTH'(1);
  localparam logic [RES_WIDTH-1:0] RES_ERR = {RES_WIDTH{1'b1}};

  logic [1:0]           state;
  logic                 last_was2;
  logic                 err_q;
  logic [RES_WIDTH-1:0] cap_q;
  logic [TO_WIDTH-1:0]  wait_cnt;
  logic                 gnt1_q;
  logic                 gnt2_q;
  logic                 rv1_q;
  logic                 rv2_q;
  logic                 res_err_q;
  logic                 div_en_q;
  logic                 sel_q;
  logic [RES_WIDTH-1:0] res_q;
  logic [WIDTH-1:0]     dd_q;
  logic [WIDTH-1:0]     dv_q;
  logic                 pick2;

  // requester 2 wins when alone, or on a tie when requester 1 was served last
  assign pick2 = bus.req2 && (!bus.req1 || !last_was2);

  // arbitration, operand latching, divider launch, completion/timeout watch
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      last_was2 <= 1'b1;  // behave as if requester 2 went last so requester 1 wins the first tie
      err_q     <= 1'b0;
      cap_q     <= '0;
      wait_cnt  <= '0;
      gnt1_q    <= 1'b0;
      gnt2_q    <= 1'b0;
      rv1_q     <= 1'b0;
      rv2_q     <= 1'b0;
      res_err_q <= 1'b0;
      div_en_q  <= 1'b0;
      sel_q     <= 1'b0;
      res_q     <= '0;
      dd_q      <= '0;
      dv_q      <= '0;
    end else begin
      gnt1_q   <= 1'b0;
      gnt2_q   <= 1'b0;
      rv1_q    <= 1'b0;
      rv2_q    <= 1'b0;
      div_en_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req1 || bus.req2) begin
            if (pick2) begin
              gnt2_q <= 1'b1;
              sel_q  <= 1'b1;
              dd_q   <= bus.dividend2;
              dv_q   <= bus.divisor2;
            end else begin
              gnt1_q <= 1'b1;
              sel_q  <= 1'b0;
              dd_q   <= bus.dividend1;
              dv_q   <= bus.divisor1;
            end
            state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          wait_cnt <= '0;
          // a zero divisor never reaches the divider
          if (dv_q == '0) begin
            cap_q <= RES_ERR;
            err_q <= 1'b1;
            state <= S_DONE;
          end else begin
            div_en_q <= 1'b1;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + TO_ONE;
          // wait_cnt == 0 is the cycle div_en is still visible, so a stale ready is ignored
          if (bus.div_ready && (wait_cnt != '0)) begin
            cap_q <= bus.div_res;
            err_q <= 1'b0;
            state <= S_DONE;
          end else if (wait_cnt == TO_LAST) begin
            cap_q <= RES_ERR;
            err_q <= 1'b1;
            state <= S_DONE;
          end
        end
        default: begin
          res_q     <= cap_q;
          res_err_q <= err_q;
          rv1_q     <= !sel_q;
          rv2_q     <= sel_q;
          last_was2 <= sel_q;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt1         = gnt1_q;
  assign bus.gnt2         = gnt2_q;
  assign bus.res          = res_q;
  assign bus.res_valid1   = rv1_q;
  assign bus.res_valid2   = rv2_q;
  assign bus.res_err      = res_err_q;
  assign bus.div_en       = div_en_q;
  assign bus.div_select   = sel_q;
  assign bus.div_dividend = dd_q;
  assign bus.div_divisor  = dv_q;
endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - scoreboard bench for div_arbiter
module tb_div_arbiter;
  localparam int WIDTH = 16;
  localparam int RW    = 12;

  typedef struct { logic [15:0] dd; logic [15:0] dv; } op_t;
  typedef struct { logic [11:0] res; logic err; } rsp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  div_arbiter_if #(.WIDTH(WIDTH), .RES_WIDTH(RW)) bus ();

  div_arbiter #(.WIDTH(WIDTH), .RES_WIDTH(RW), .TIMEOUT(64), .TO_WIDTH(7)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  op_t   ops1[$];
  op_t   ops2[$];
  rsp_t  exp1[$];
  rsp_t  exp2[$];
  int    exp_gnt[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    t_gnt = 0, t_en = 0, t_rv = 0;
  int    n_en = 0, rv_cnt = 0, own = 1;
  int    div_dly = 0, dcnt = 0;
  bit    sticky = 0;
  logic [15:0] bfm_dd = '0, bfm_dv = '0;
  logic [11:0] dq = '0;

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, expv);
    end
  endtask

  task automatic issue(input int id, input int dd, input int dv, input bit want_rsp);
    op_t o;
    rsp_t r;
    o.dd = 16'(dd);
    o.dv = 16'(dv);
    r.err = (dv == 0) || (div_dly == 0);
    r.res = r.err ? 12'hFFF : 12'(dd / dv);
    if (id == 1) ops1.push_back(o); else ops2.push_back(o);
    if (want_rsp) begin
      if (id == 1) exp1.push_back(r); else exp2.push_back(r);
    end
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while ((ops1.size() + ops2.size() + exp1.size() + exp2.size() + exp_gnt.size()) != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk(nm, int'(n < budget), 1);
    repeat (3) @(negedge clock);
  endtask

  // requester BFMs and divider model
  always @(negedge clock) begin
    if (bus.gnt1 && ops1.size() > 0) begin
      bfm_dd = ops1[0].dd; bfm_dv = ops1[0].dv; void'(ops1.pop_front());
    end
    if (bus.gnt2 && ops2.size() > 0) begin
      bfm_dd = ops2[0].dd; bfm_dv = ops2[0].dv; void'(ops2.pop_front());
    end
    bus.req1 = ops1.size() > 0;
    bus.req2 = ops2.size() > 0;
    if (ops1.size() > 0) begin bus.dividend1 = ops1[0].dd; bus.divisor1 = ops1[0].dv; end
    else begin bus.dividend1 = '0; bus.divisor1 = '0; end
    if (ops2.size() > 0) begin bus.dividend2 = ops2[0].dd; bus.divisor2 = ops2[0].dv; end
    else begin bus.dividend2 = '0; bus.divisor2 = '0; end
    if (bus.div_en) begin
      dcnt = div_dly;
      dq = (bfm_dv != 0) ? 12'(bfm_dd / bfm_dv) : 12'hFFF;
      if (!sticky) bus.div_ready = 1'b0;
    end else if (dcnt > 0) begin
      dcnt--;
      bus.div_ready = (dcnt == 1) || (sticky && dcnt == 0);
      if (dcnt == 1) bus.div_res = dq;
    end
    if (bus.div_ready === 1'bx) bus.div_ready = 1'b0;
    if (bus.div_res === 12'bx) bus.div_res = '0;
    bus.div_busy = dcnt > 0;
  end

  // scoreboard monitor
  always @(negedge clock) begin
    rsp_t r;
    cyc++;
    if (bus.gnt1 || bus.gnt2) begin
      t_gnt = cyc;
      chk("gnt_onehot", int'(bus.gnt1 & bus.gnt2), 0);
      if (exp_gnt.size() == 0) begin
        total++; bad++;
        $display("FAIL gnt_unexpected: got gnt1=%0d gnt2=%0d want none", bus.gnt1, bus.gnt2);
      end else begin
        own = exp_gnt.pop_front();
        chk("gnt_id", bus.gnt2 ? 2 : 1, own);
      end
    end
    if (bus.div_en) begin
      t_en = cyc;
      n_en++;
      chk("en_select", int'(bus.div_select), own - 1);
      chk("en_dividend", int'(bus.div_dividend), int'(bfm_dd));
      chk("en_divisor", int'(bus.div_divisor), int'(bfm_dv));
      chk("en_nonzero", int'(bfm_dv != 0), 1);
    end
    if (bus.res_valid1 || bus.res_valid2) begin
      t_rv = cyc;
      rv_cnt++;
      chk("rv_onehot", int'(bus.res_valid1 & bus.res_valid2), 0);
      chk("rv_select", int'(bus.div_select), bus.res_valid2 ? 1 : 0);
      if ((bus.res_valid1 && exp1.size() == 0) || (bus.res_valid2 && exp2.size() == 0)) begin
        total++; bad++;
        $display("FAIL rv_unexpected: got res_valid1=%0d res_valid2=%0d want none", bus.res_valid1, bus.res_valid2);
      end else begin
        r = bus.res_valid1 ? exp1.pop_front() : exp2.pop_front();
        chk("rv_res", int'(bus.res), int'(r.res));
        chk("rv_err", int'(bus.res_err), int'(r.err));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int n0, k, rv0;
    repeat (2) @(negedge clock);
    chk("rst_gnt", int'({bus.gnt1, bus.gnt2}), 0);
    chk("rst_rv", int'({bus.res_valid1, bus.res_valid2, bus.res_err}), 0);
    chk("rst_div", int'({bus.div_en, bus.div_select}), 0);
    chk("rst_res", int'(bus.res), 0);
    chk("rst_ops", int'({bus.div_dividend, bus.div_divisor}), 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // single request, ready 13 cycles after start
    div_dly = 13;
    exp_gnt.push_back(1);
    issue(1, 1000, 40, 1);
    wait_done("single_done", 100);
    chk("single_en_lat", t_en - t_gnt, 1);
    chk("single_rv_lat", t_rv - t_en, 14);

    // divide by zero from requester 2
    n0 = n_en;
    exp_gnt.push_back(2);
    issue(2, 500, 0, 1);
    wait_done("dz_done", 50);
    chk("dz_no_en", n_en, n0);
    chk("dz_rv_lat", t_rv - t_gnt, 2);

    // contention, both held: 1,2,1,2
    div_dly = 5;
    exp_gnt.push_back(1); exp_gnt.push_back(2); exp_gnt.push_back(1); exp_gnt.push_back(2);
    issue(1, 300, 3, 1);
    issue(2, 900, 4, 1);
    issue(1, 50000, 5, 1);
    issue(2, 65535, 16, 1);
    wait_done("cont_done", 200);

    // timeout, then a normal op
    div_dly = 0;
    exp_gnt.push_back(1);
    issue(1, 1234, 2, 1);
    wait_done("to_done", 200);
    chk("to_lat", t_rv - t_en, 65);
    div_dly = 4;
    exp_gnt.push_back(1);
    issue(1, 1234, 2, 1);
    wait_done("to_next_done", 100);

    // stale ready held from previous op
    sticky = 1;
    div_dly = 6;
    exp_gnt.push_back(1); exp_gnt.push_back(1);
    issue(1, 800, 8, 1);
    issue(1, 900, 3, 1);
    wait_done("stale_done", 100);
    chk("stale_rv_lat", t_rv - t_en, 7);
    sticky = 0;

    // reset in the middle of WAIT
    div_dly = 0;
    n0 = n_en;
    exp_gnt.push_back(1);
    issue(1, 4321, 3, 0);
    k = 0;
    while (n_en == n0 && k < 100) begin @(negedge clock); k++; end
    chk("mid_en_seen", int'(n_en != n0), 1);
    repeat (5) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("mid_gnt", int'({bus.gnt1, bus.gnt2}), 0);
    chk("mid_rv", int'({bus.res_valid1, bus.res_valid2, bus.res_err}), 0);
    chk("mid_div", int'({bus.div_en, bus.div_select}), 0);
    chk("mid_res", int'(bus.res), 0);
    chk("mid_ops", int'({bus.div_dividend, bus.div_divisor}), 0);
    ops1.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    rv0 = rv_cnt;
    n0 = n_en;
    repeat (8) @(negedge clock);
    chk("mid_no_stray_rv", rv_cnt, rv0);
    chk("mid_no_stray_en", n_en, n0);

    div_dly = 3;
    exp_gnt.push_back(1); exp_gnt.push_back(2);
    issue(1, 100, 10, 1);
    issue(2, 200, 10, 1);
    wait_done("post_both_done", 100);
    exp_gnt.push_back(2);
    issue(2, 99, 9, 1);
    wait_done("post_req2_done", 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
Sequences and shares the single divider between the instantaneous-speed and average-speed calculators. Accepts requests from two requesters, arbitrates round-robin, latches the winner's operands, launches the divider, and watches for completion or timeout. Returns the quotient with a per-requester valid/error pulse. Sits between the Speed/Average_speed blocks and the divider, replacing ad-hoc div_select/en generation in control.

Parameters:
WIDTH, 16, operand width (dividend and divisor)
RES_WIDTH, 12, divider quotient width
TIMEOUT, 64, max WAIT cycles before abort (must be ≥2)
TO_WIDTH, 7, timeout counter width (must hold TIMEOUT)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req1  in  1  speed requester request (level)
dividend1  in  WIDTH  speed dividend
divisor1  in  WIDTH  speed divisor
req2  in  1  avg-speed requester request (level)
dividend2  in  WIDTH  avg-speed dividend
divisor2  in  WIDTH  avg-speed divisor
gnt1  out  1  one-cycle accept pulse to requester 1
gnt2  out  1  one-cycle accept pulse to requester 2
res  out  RES_WIDTH  shared result bus, held until next completion
res_valid1  out  1  one-cycle completion pulse, requester 1
res_valid2  out  1  one-cycle completion pulse, requester 2
res_err  out  1  qualifies res_validN: 1 = divide-by-zero or timeout
div_en  out  1  divider start pulse
div_select  out  1  0 = requester 1 owns divider, 1 = requester 2
div_dividend  out  WIDTH  latched dividend to divider
div_divisor  out  WIDTH  latched divisor to divider
div_busy  in  1  divider busy
div_ready  in  1  divider result ready
div_res  in  RES_WIDTH  divider quotient

Behaviour:
- Clock and reset: single clock; reset is asynchronous and active-low. All outputs are registered.
- Reset values: every output is 0, state = IDLE, last_grant = 1 (so requester 1 wins first), timeout counter = 0.
- States: IDLE, LAUNCH, WAIT, DONE.
- IDLE, no request: stay in IDLE.
- IDLE, exactly one reqN high:
  - gntN <= 1 (high for exactly one cycle).
  - Latch dividendN/divisorN into div_dividend/div_divisor.
  - div_select <= N-1; owner <= N.
- IDLE, both requests high: grant the requester not equal to last_grant.
- After a grant, divisor == 0: go to DONE with err = 1 and result = all ones; div_en is never asserted.
- After a grant, divisor != 0: go to LAUNCH.
- LAUNCH: div_en <= 1 for exactly one cycle; clear the counter; go to WAIT.
- WAIT:
  - div_ready is ignored in the first WAIT cycle, while div_en is still visible to the divider.
  - From the second WAIT cycle, div_ready = 1 captures div_res into res with err = 0; go to DONE.
  - The counter increments each WAIT cycle. When it reaches TIMEOUT with no ready: res <= all ones, err = 1, go to DONE.
- DONE:
  - res_valid(owner) <= 1 for one cycle, with res_err = err.
  - last_grant <= owner; return to IDLE.
- Output stability: div_select, div_dividend and div_divisor stay constant from grant until the DONE cycle ends. res holds until the next DONE.
- Latency, req1 high in IDLE at edge k, divider ready d cycles after its start:
  - gnt1 at k+1
  - div_en at k+2
  - res_valid1 at k+3+d (minimum k+4)
  - Next grant is possible at k+4+d.
- Requester handshake:
  - The requester must drop req on the cycle it sees gnt.
  - If req is still high when the block re-enters IDLE, it counts as a new request.
  - Operand inputs are sampled only on the grant edge.
- Simultaneous events:
  - A req arriving in LAUNCH, WAIT or DONE waits (it is not lost while held).
  - Both requests high continuously: grants strictly alternate 1, 2, 1, 2.
- Reset mid-operation: the block aborts immediately. No res_valid is emitted and div_en is low. After release, the first grant goes to requester 1.
- div_busy: monitored only for debug, does not affect sequencing; ignored.
- Width rule: res = div_res[RES_WIDTH-1:0] unchanged; the all-ones error value is {RES_WIDTH{1'b1}}.

Test Plan:
- Single request: req1 with 1000/40, divider ready 13 cycles after div_en → gnt1 one cycle later; div_en next cycle with div_select = 0; res_valid1 with res = 25, res_err = 0; no gnt2/res_valid2 ever.
- Contention: req1 and req2 rise on the same cycle and are held → first grant to 1; after res_valid1, grant to 2 with div_select = 1; over 4 ops the grant sequence is 1, 2, 1, 2.
- Divide-by-zero: req2 with divisor = 0 → gnt2, no div_en, res_valid2 two cycles after gnt2, res = 0xFFF, res_err = 1.
- Timeout: divider never asserts ready, TIMEOUT = 64 → res_valid1 exactly 64 WAIT cycles after entering WAIT, res = 0xFFF, res_err = 1; next request still serviced normally.
- Stale ready: div_ready held high from the previous op during the first WAIT cycle → not captured; result taken from the next ready-high cycle.
- Reset mid-WAIT: pull reset low during WAIT → all outputs 0 asynchronously; after release, no stray res_valid; next req2 is served, and with both requests present requester 1 is served first.
